thumb_inst_align: RTL and testbench

//  Fetch-to-decode aligner for the Thumb-2 front end. Buffers 32-bit fetch words as halfwords.

---
 rtl/thumb_inst_align_pkg.sv | 25 ++
 rtl/thumb_inst_align_hw_fifo.sv | 66 ++++++
 rtl/thumb_inst_align.sv | 90 +++++++++
 tb/tb_thumb_inst_align.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/thumb_inst_align_pkg.sv
// Shared definitions for the Thumb-2 fetch aligner: 32-bit prefix macros and instruction length helper.
// Also hosts `T32_PFX_*, `HW_NOP and `T32_IS32 for reuse by decode-side checkers.
`ifndef INST_ALIGN_DEFS
`define INST_ALIGN_DEFS
`define T32_PFX_A 5'b11101
`define T32_PFX_B 5'b11110
`define T32_PFX_C 5'b11111
`define HW_NOP 16'hBF00
`define T32_IS32(hw) (((hw[15:11]) == `T32_PFX_A) || ((hw[15:11]) == `T32_PFX_B) || ((hw[15:11]) == `T32_PFX_C))
`endif

package thumb_inst_align_pkg;

  localparam int unsigned HW_W = 16;

  typedef enum logic {
    LEN16 = 1'b0,
    LEN32 = 1'b1
  } inst_len_e;

  function automatic inst_len_e inst_len(input logic [HW_W-1:0] hw);
    return `T32_IS32(hw) ? LEN32 : LEN16;
  endfunction

endpackage

// File: rtl/thumb_inst_align_hw_fifo.sv
// HW_DEPTH x 16 circular halfword buffer: writes 0/1/2 halfwords, reads head pair, pops 0/1/2.
module hw_fifo
  import thumb_inst_align_pkg::*;
#(
  parameter int unsigned HW_DEPTH = 6,
  parameter int unsigned PTR_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [1:0]        wr_n,
  input  logic [HW_W-1:0]   wr_hw0,
  input  logic [HW_W-1:0]   wr_hw1,
  input  logic [1:0]        pop_n,
  output logic [HW_W-1:0]   hw0,
  output logic [HW_W-1:0]   hw1,
  output logic [PTR_W:0]    count
);

  logic [HW_W-1:0]  mem [HW_DEPTH];
  logic [PTR_W-1:0] rd;
  logic [PTR_W-1:0] wr;

  // Pointer advance modulo HW_DEPTH (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W-1:0] p, input logic [1:0] n);
    int unsigned s;
    s = 32'(p) + 32'(n);
    if (s >= HW_DEPTH) s = s - HW_DEPTH;
    return PTR_W'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (!clr) begin
      if (wr_n != 2'd0) mem[wr] <= wr_hw0;
      if (wr_n == 2'd2) mem[wrap(wr, 2'd1)] <= wr_hw1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (clr) begin
      rd    <= wr;
      count <= '0;
    end else begin
      wr    <= wrap(wr, wr_n);
      rd    <= wrap(rd, pop_n);
      count <= count + (PTR_W+1)'(wr_n) - (PTR_W+1)'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr) begin
      assert (32'(count) + 32'(wr_n) <= HW_DEPTH + 32'(pop_n));
      assert (32'(pop_n) <= 32'(count));
    end
  end

  always_comb begin
    hw0 = mem[rd];
    hw1 = mem[wrap(rd, 2'd1)];
  end

endmodule

// File: rtl/thumb_inst_align.sv
// Thumb-2 fetch-to-decode aligner: presents one whole 16/32-bit instruction per handshake.
// Optional `INST_ALIGN_PC_EN adds a pc register driving inst_pc.
module thumb_inst_align
  import thumb_inst_align_pkg::*;
#(
  parameter int unsigned HW_DEPTH = 6,
  parameter int unsigned PTR_W    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic        inst_is32,
  output logic [31:0] inst_pc
);

  logic [PTR_W:0]    count;
  logic [HW_W-1:0]   hw0;
  logic [HW_W-1:0]   hw1;
  logic [HW_W-1:0]   wr_hw0;
  logic [1:0]        wr_n;
  logic [1:0]        pop_n;
  logic              push;
  logic              pop;
  logic              drop_lo;
  inst_len_e         len;

  hw_fifo #(
    .HW_DEPTH (HW_DEPTH),
    .PTR_W    (PTR_W)
  ) u_hw_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .wr_n   (wr_n),
    .wr_hw0 (wr_hw0),
    .wr_hw1 (fetch_data[31:16]),
    .pop_n  (pop_n),
    .hw0    (hw0),
    .hw1    (hw1),
    .count  (count)
  );

  always_comb begin
    len         = inst_len(hw0);
    inst_valid  = ((count != '0) && (len == LEN16)) || (count > (PTR_W+1)'(1));
    fetch_ready = !flush && (32'(count) <= HW_DEPTH - 2);
    push        = fetch_valid && fetch_ready;
    pop         = inst_valid && inst_ready && !flush;
    wr_n        = push ? (drop_lo ? 2'd1 : 2'd2) : 2'd0;
    wr_hw0      = drop_lo ? fetch_data[31:16] : fetch_data[15:0];
    pop_n       = pop ? ((len == LEN32) ? 2'd2 : 2'd1) : 2'd0;
    inst_is32   = inst_valid && (len == LEN32);
    // Gate on inst_valid so the outputs read zero while the buffer is empty or half-filled.
    inst        = inst_valid ? {hw0, (inst_is32 ? hw1 : 16'h0000)} : 32'h0000_0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       drop_lo <= 1'b0;
    else if (flush) drop_lo <= flush_pc[1];
    else if (push) drop_lo <= 1'b0;
  end

`ifdef INST_ALIGN_PC_EN
  logic [31:0] pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pc <= '0;
    else if (flush) pc <= {flush_pc[31:1], 1'b0};
    else if (pop)   pc <= pc + ((len == LEN32) ? 32'd4 : 32'd2);
  end

  always_comb inst_pc = pc;

  logic unused_flush_pc;
  always_comb unused_flush_pc = flush_pc[0];
`else
  always_comb inst_pc = '0;

  logic unused_flush_pc;
  always_comb unused_flush_pc = ^{flush_pc[31:2], flush_pc[0]};
`endif

endmodule

// File: tb/tb_thumb_inst_align.sv
// Directed scoreboard bench for thumb_inst_align; expected instructions are queued as words are driven.
module tb_thumb_inst_align;

  localparam int unsigned HW_DEPTH = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        flush;
  logic [31:0] flush_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        inst_is32;
  logic [31:0] inst_pc;

  thumb_inst_align #(
    .HW_DEPTH (HW_DEPTH),
    .PTR_W    (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_data  (fetch_data),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_is32   (inst_is32),
    .inst_pc     (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        is32;
    logic [31:0] pc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          hw_cnt = 0;
  logic        drop = 1'b0;
  logic [31:0] model_pc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] i, input logic l);
    exp_t e;
    e.inst = i;
    e.is32 = l;
`ifdef INST_ALIGN_PC_EN
    e.pc = model_pc;
`else
    e.pc = '0;
`endif
    model_pc = model_pc + (l ? 32'd4 : 32'd2);
    q.push_back(e);
  endtask

  task automatic step(input logic fv, input logic [31:0] fd, input logic ir,
                      input logic fl, input logic [31:0] fpc);
    logic exp_ready;
    logic exp_valid;
    @(negedge clk);
    fetch_valid = fv;
    fetch_data  = fd;
    inst_ready  = ir;
    flush       = fl;
    flush_pc    = fpc;
    #1;
    exp_ready = !fl && (hw_cnt <= int'(HW_DEPTH) - 2);
    exp_valid = (q.size() > 0) && (hw_cnt >= (q[0].is32 ? 2 : 1));
    chk("fetch_ready", 32'(fetch_ready), 32'(exp_ready));
    chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
    if (exp_valid && inst_valid) begin
      chk("inst", inst, q[0].inst);
      chk("inst_is32", 32'(inst_is32), 32'(q[0].is32));
      chk("inst_pc", inst_pc, q[0].pc);
      if (ir && !fl) begin
        hw_cnt = hw_cnt - (q[0].is32 ? 2 : 1);
        void'(q.pop_front());
      end
    end
    if (fl) begin
      q.delete();
      hw_cnt   = 0;
      drop     = fpc[1];
      model_pc = {fpc[31:1], 1'b0};
    end else if (fv && exp_ready) begin
      hw_cnt = hw_cnt + (drop ? 1 : 2);
      drop   = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic ir, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step(1'b0, 32'h0, ir, 1'b0, 32'h0);
  endtask

  task automatic word(input logic [31:0] d, input logic ir);
    step(1'b1, d, ir, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_data = '0; flush = 1'b0; flush_pc = '0; inst_ready = 1'b0;
    #2;
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_is32", 32'(inst_is32), 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    @(negedge clk); rst = 1'b0;

    // 1: two 16-bit instructions popped back-to-back
    push_exp(32'h1C4A_0000, 1'b0);
    push_exp(32'h4448_0000, 1'b0);
    word(32'h4448_1C4A, 1'b1);
    idle(1'b1, 3);

    // 2: 32-bit then two 16-bit
    push_exp(32'hF141_0001, 1'b1);
    push_exp(32'h4148_0000, 1'b0);
    push_exp(32'h1C4A_0000, 1'b0);
    word(32'h0001_F141, 1'b1);
    word(32'h1C4A_4148, 1'b1);
    idle(1'b1, 4);

    // 3: 32-bit instruction straddling two fetch words
    push_exp(32'h1C4A_0000, 1'b0);
    push_exp(32'hF141_0001, 1'b1);
    push_exp(32'h4148_0000, 1'b0);
    word(32'hF141_1C4A, 1'b1);
    idle(1'b1, 2);
    word(32'h4148_0001, 1'b1);
    idle(1'b1, 3);

    // 4: backpressure with continuous fetch
    for (int unsigned i = 0; i < 5; i++) begin
      logic [15:0] lo;
      logic [15:0] hi;
      lo = 16'h2000 + 16'(i);
      hi = 16'h2100 + 16'(i);
      if (hw_cnt <= int'(HW_DEPTH) - 2) begin
        push_exp({lo, 16'h0000}, 1'b0);
        push_exp({hi, 16'h0000}, 1'b0);
      end
      word({hi, lo}, 1'b0);
    end
    chk("full_count", 32'(hw_cnt), 32'(HW_DEPTH));
    idle(1'b1, 8);

    // 5: flush to upper halfword discards buffered instructions
    push_exp(32'h1C4A_0000, 1'b0);
    push_exp(32'h4448_0000, 1'b0);
    word(32'h4448_1C4A, 1'b0);
    step(1'b1, 32'h3333_3333, 1'b1, 1'b1, 32'h0000_1002);
    push_exp(32'hBF00_0000, 1'b0);
    word(32'hBF00_1C4A, 1'b1);
    idle(1'b1, 3);

    // 6: async reset with three halfwords buffered
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_2002);
    push_exp(32'h3000_0000, 1'b0);
    word(32'h3000_1C4A, 1'b0);
    push_exp(32'h2111_0000, 1'b0);
    push_exp(32'h2222_0000, 1'b0);
    word(32'h2222_2111, 1'b0);
    idle(1'b0, 1);
    chk("pre_rst_count", 32'(hw_cnt), 32'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(inst_valid), 32'd0);
    chk("async_rst_inst", inst, 32'd0);
    chk("async_rst_ready", 32'(fetch_ready), 32'd1);
    q.delete(); hw_cnt = 0; drop = 1'b0; model_pc = '0;
    @(negedge clk); rst = 1'b0;
    push_exp(32'h1C4A_0000, 1'b0);
    push_exp(32'h4448_0000, 1'b0);
    word(32'h4448_1C4A, 1'b1);
    idle(1'b1, 3);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
